// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO.
// Frame format (data width, parity, stop bits) and baud divisor are fixed at elaboration.
module fifo_uart_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CLKDIV   = 868,
  parameter int unsigned PARITY   = 0,
  parameter int unsigned STOPBITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             notempty,
  input  logic [WIDTH-1:0] fifodout,
  output logic             fiford,
  output logic             txd,
  output logic             busy
);

  localparam int unsigned TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned IW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKDIV - 1);
  localparam logic [IW-1:0] D_LAST  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] S_LAST  = IW'(STOPBITS - 1);
  localparam bit            HAS_PAR = (PARITY != 0);
  localparam bit            ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_sh;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             last_stop;
  logic             ld;

  assign tick      = (timer_q == T_LAST);
  assign last_stop = (state_q == S_STOP) && tick && (idx_q == S_LAST);
  // Gated by rst_n so a word is never popped on an edge that will discard the load.
  assign ld        = rst_n && enable && notempty && ((state_q == S_IDLE) || last_stop);
  assign shreg_sh  = shreg_q >> 1;

  assign fiford = ld;
  assign txd    = txd_q;
  assign busy   = busy_q;

  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == D_LAST) begin
            idx_d = '0;
            if (HAS_PAR) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shreg_d = shreg_sh;
            idx_d   = idx_q + 1'b1;
            txd_d   = shreg_sh[0];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (idx_q == S_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A load overrides the stop-to-idle exit so back-to-back frames have no gap.
    if (ld) begin
      state_d = S_START;
      timer_d = '0;
      idx_d   = '0;
      shreg_d = fifodout;
      par_d   = (^fifodout) ^ ODD_PAR;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: an 8N1 instance and an 8O2 instance, both CLKDIV=4.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable1, notempty1, fiford1, txd1, busy1;
  logic [7:0] fifodout1;
  logic       enable2, notempty2, fiford2, txd2, busy2;
  logic [7:0] fifodout2;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKDIV(4), .PARITY(0), .STOPBITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .notempty(notempty1),
    .fifodout(fifodout1), .fiford(fiford1), .txd(txd1), .busy(busy1)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKDIV(4), .PARITY(2), .STOPBITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .notempty(notempty2),
    .fifodout(fifodout2), .fiford(fiford2), .txd(txd2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level for cycle i of a frame (i=0 is the cycle after the load edge).
  function automatic logic exp_txd(input logic [7:0] d, input int unsigned i, input bit odd2);
    int unsigned slot;
    slot = i / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (odd2 && slot == 9) return ~^d;
    return 1'b1;
  endfunction

  // Called at the negedge of the cycle whose fiford loads word d on the next edge.
  task automatic run_frame(input bit sel, input logic [7:0] d, input bit next_valid,
                           input logic [7:0] next_data, input int drop_en_at,
                           input int abort_at, output logic par_seen);
    int unsigned f;
    int unsigned busy_cnt;
    int unsigned pops;
    logic t, b, r, e;
    f = sel ? 48 : 40;
    busy_cnt = 0;
    pops = 0;
    par_seen = 1'bx;
    for (int i = 0; i < int'(f); i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (sel) begin
          if (next_valid) fifodout2 = next_data; else notempty2 = 1'b0;
        end else begin
          if (next_valid) fifodout1 = next_data; else notempty1 = 1'b0;
        end
      end
      if (i == drop_en_at) begin
        if (sel) enable2 = 1'b0; else enable1 = 1'b0;
      end
      #1;
      t = sel ? txd2 : txd1;
      b = sel ? busy2 : busy1;
      r = sel ? fiford2 : fiford1;
      e = sel ? enable2 : enable1;
      check(sel ? "txd2" : "txd1", {31'd0, t}, {31'd0, exp_txd(d, i, sel)});
      if (b) busy_cnt++;
      if (i < int'(f) - 1 && r) pops++;
      if (sel && i == 37) par_seen = t;
      if (i == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      if (i == int'(f) - 1) check("end_pop", {31'd0, r}, {31'd0, next_valid & e});
    end
    check("busy_len", busy_cnt, f);
    check("mid_pops", pops, 0);
  endtask

  initial begin
    logic par;
    int unsigned bad;

    rst_n = 1'b0;
    enable1 = 1'b0; notempty1 = 1'b0; fifodout1 = '0;
    enable2 = 1'b0; notempty2 = 1'b0; fifodout2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_txd1", txd1, 1);
    check("rst_busy1", busy1, 0);
    check("rst_rd1", fiford1, 0);
    check("rst_txd2", txd2, 1);
    check("rst_busy2", busy2, 0);

    // Single 0x55 frame
    @(negedge clk);
    enable1 = 1'b1; notempty1 = 1'b1; fifodout1 = 8'h55;
    #1;
    check("ld_55", fiford1, 1);
    run_frame(0, 8'h55, 0, 8'h00, -1, -1, par);
    @(negedge clk); #1;
    check("idle_txd", txd1, 1);
    check("idle_busy", busy1, 0);

    // Back-to-back 0xA5 then 0x3C
    @(negedge clk);
    notempty1 = 1'b1; fifodout1 = 8'hA5;
    #1;
    check("ld_a5", fiford1, 1);
    run_frame(0, 8'hA5, 1, 8'h3C, -1, -1, par);
    run_frame(0, 8'h3C, 0, 8'h00, -1, -1, par);
    @(negedge clk); #1;
    check("b2b_idle_txd", txd1, 1);
    check("b2b_idle_busy", busy1, 0);

    // Empty FIFO for 200 cycles
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || fiford1 !== 1'b0) bad++;
    end
    check("empty_bad", bad, 0);

    // Disabled with a word waiting
    bad = 0;
    @(negedge clk);
    enable1 = 1'b0; notempty1 = 1'b1; fifodout1 = 8'h12;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fiford1 !== 1'b0 || busy1 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("dis_bad", bad, 0);
    enable1 = 1'b1;
    #1;
    check("en_ld", fiford1, 1);
    run_frame(0, 8'h12, 0, 8'h00, -1, -1, par);

    // Enable dropped during data bit 3 of 0xFF, FIFO keeps a word
    @(negedge clk);
    notempty1 = 1'b1; fifodout1 = 8'hFF;
    #1;
    check("ld_ff", fiford1, 1);
    run_frame(0, 8'hFF, 1, 8'hEE, 17, -1, par);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (fiford1 !== 1'b0 || busy1 !== 1'b0 || txd1 !== 1'b1) bad++;
    end
    check("dropen_bad", bad, 0);

    // Reset during data bit 5 of 0x96
    @(negedge clk);
    enable1 = 1'b1; notempty1 = 1'b1; fifodout1 = 8'h96;
    #1;
    check("ld_96", fiford1, 1);
    run_frame(0, 8'h96, 0, 8'h00, -1, 25, par);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_txd", txd1, 1);
    check("mrst_busy", busy1, 0);
    check("mrst_rd", fiford1, 0);
    @(negedge clk);
    notempty1 = 1'b1; fifodout1 = 8'h3A;
    #1;
    check("mrst_idle_ld", fiford1, 1);
    run_frame(0, 8'h3A, 0, 8'h00, -1, -1, par);

    // Odd parity, two stop bits
    @(negedge clk);
    enable2 = 1'b1; notempty2 = 1'b1; fifodout2 = 8'h00;
    #1;
    check("ld2_00", fiford2, 1);
    run_frame(1, 8'h00, 1, 8'h01, -1, -1, par);
    check("par_00", par, 1);
    run_frame(1, 8'h01, 0, 8'h00, -1, -1, par);
    check("par_01", par, 0);
    @(negedge clk); #1;
    check("idle2_txd", txd2, 1);
    check("idle2_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
